// File: rtl/bp_me_dma_arbiter_if.sv
// Handshake bundle between the cache-side DMA requesters and the single
// memory-side DMA port. The arbiter uses the master view; the surrounding
// caches and memory use the slave view.
interface bp_me_dma_arbiter_if #(
  parameter int num_dma_p       = 2,
  parameter int dma_pkt_width_p = 46,
  parameter int fill_width_p    = 64
);
  logic [num_dma_p-1:0][dma_pkt_width_p-1:0] dma_pkt_i;
  logic [num_dma_p-1:0]                      dma_pkt_v_i;
  logic [num_dma_p-1:0]                      dma_pkt_yumi_o;

  logic [num_dma_p-1:0][fill_width_p-1:0]    dma_data_o;
  logic [num_dma_p-1:0]                      dma_data_v_o;
  logic [num_dma_p-1:0]                      dma_data_ready_and_i;

  logic [num_dma_p-1:0][fill_width_p-1:0]    dma_data_i;
  logic [num_dma_p-1:0]                      dma_data_v_i;
  logic [num_dma_p-1:0]                      dma_data_yumi_o;

  logic [dma_pkt_width_p-1:0]                mem_dma_pkt_o;
  logic                                      mem_dma_pkt_v_o;
  logic                                      mem_dma_pkt_yumi_i;

  logic [fill_width_p-1:0]                   mem_dma_data_i;
  logic                                      mem_dma_data_v_i;
  logic                                      mem_dma_data_ready_and_o;

  logic [fill_width_p-1:0]                   mem_dma_data_o;
  logic                                      mem_dma_data_v_o;
  logic                                      mem_dma_data_yumi_i;

  modport master (
    input  dma_pkt_i, dma_pkt_v_i, dma_data_ready_and_i, dma_data_i, dma_data_v_i,
    input  mem_dma_pkt_yumi_i, mem_dma_data_i, mem_dma_data_v_i, mem_dma_data_yumi_i,
    output dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o,
    output mem_dma_pkt_o, mem_dma_pkt_v_o, mem_dma_data_ready_and_o,
    output mem_dma_data_o, mem_dma_data_v_o
  );

  modport slave (
    output dma_pkt_i, dma_pkt_v_i, dma_data_ready_and_i, dma_data_i, dma_data_v_i,
    output mem_dma_pkt_yumi_i, mem_dma_data_i, mem_dma_data_v_i, mem_dma_data_yumi_i,
    input  dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o,
    input  mem_dma_pkt_o, mem_dma_pkt_v_o, mem_dma_data_ready_and_o,
    input  mem_dma_data_o, mem_dma_data_v_o
  );
endinterface

// File: rtl/bp_me_dma_arbiter.sv
// Round-robin arbiter merging several cache DMA ports onto one memory DMA port.
// Reads are tracked in an in-order FIFO of requester ids so returning beats are
// steered to the right cache; writes stream their beats straight through.
// Optional macro BP_ME_DMA_ARBITER_CHECK_EN compiles in simulation-only checks.
//
//   state   | meaning
//   e_idle  | arbitrating / presenting packets to memory
//   e_wdata | forwarding write beats from requester wid_r
module bp_me_dma_arbiter #(
  parameter int num_dma_p       = 2,
  parameter int dma_pkt_width_p = 46,
  parameter int fill_width_p    = 64,
  parameter int fill_beats_p    = 8,
  parameter int rd_fifo_els_p   = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_me_dma_arbiter_if.master bus
);
  localparam int sel_w  = (num_dma_p > 1) ? $clog2(num_dma_p) : 1;
  localparam int fptr_w = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
  localparam int fcnt_w = $clog2(rd_fifo_els_p + 1);
  localparam int beat_w = (fill_beats_p > 1) ? $clog2(fill_beats_p) : 1;
  localparam logic [sel_w-1:0]  last_sel  = sel_w'(num_dma_p - 1);
  localparam logic [fptr_w-1:0] last_fptr = fptr_w'(rd_fifo_els_p - 1);
  localparam logic [beat_w-1:0] last_beat = beat_w'(fill_beats_p - 1);

  typedef enum logic {e_idle, e_wdata} state_e;

  state_e               state_r, state_n;
  logic [sel_w-1:0]     rr_ptr_r, lock_sel_r, wid_r, sel, arb_sel, head;
  logic [sel_w:0]       arb_sum;
  logic                 lock_r, arb_found;
  logic [num_dma_p-1:0] eligible;
  logic [beat_w-1:0]    wbeat_r, rbeat_r;
  logic [sel_w-1:0]     fifo_mem [rd_fifo_els_p];
  logic [fptr_w-1:0]    fifo_wptr_r, fifo_rptr_r;
  logic [fcnt_w-1:0]    fifo_cnt_r;
  logic                 fifo_full, fifo_empty;
  logic                 pkt_v, pkt_go, pkt_wnr, push, pop, wbeat_go, rbeat_go;

  assign fifo_full  = (fifo_cnt_r == fcnt_w'(rd_fifo_els_p));
  assign fifo_empty = (fifo_cnt_r == '0);
  assign head       = fifo_mem[fifo_rptr_r];

  // A read can only compete while the return FIFO has room for its id.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_dma_p; i++)
      eligible[i] = bus.dma_pkt_v_i[i] & (bus.dma_pkt_i[i][dma_pkt_width_p-1] | ~fifo_full);
  end

  // First eligible requester at or after the priority pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_sum   = '0;
    for (int off = 0; off < num_dma_p; off++) begin
      arb_sum = {1'b0, rr_ptr_r} + (sel_w+1)'(off);
      if (arb_sum >= (sel_w+1)'(num_dma_p))
        arb_sum = arb_sum - (sel_w+1)'(num_dma_p);
      if (!arb_found && eligible[arb_sum[sel_w-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = arb_sum[sel_w-1:0];
      end
    end
  end

  // Next state and all outputs; everything is forced low while reset is held.
  always_comb begin
    state_n  = state_r;
    sel      = lock_r ? lock_sel_r : arb_sel;
    pkt_v    = 1'b0;
    pkt_go   = 1'b0;
    pkt_wnr  = 1'b0;
    wbeat_go = 1'b0;
    rbeat_go = 1'b0;
    bus.dma_pkt_yumi_o           = '0;
    bus.dma_data_o               = '0;
    bus.dma_data_v_o             = '0;
    bus.dma_data_yumi_o          = '0;
    bus.mem_dma_pkt_o            = '0;
    bus.mem_dma_pkt_v_o          = 1'b0;
    bus.mem_dma_data_ready_and_o = 1'b0;
    bus.mem_dma_data_o           = '0;
    bus.mem_dma_data_v_o         = 1'b0;
    if (reset_n_i) begin
      if (state_r == e_idle) begin
        pkt_v   = lock_r ? bus.dma_pkt_v_i[lock_sel_r] : arb_found;
        pkt_wnr = bus.dma_pkt_i[sel][dma_pkt_width_p-1];
        pkt_go  = pkt_v & bus.mem_dma_pkt_yumi_i;
        bus.mem_dma_pkt_v_o     = pkt_v;
        bus.mem_dma_pkt_o       = bus.dma_pkt_i[sel];
        bus.dma_pkt_yumi_o[sel] = pkt_go;
        if (pkt_go && pkt_wnr)
          state_n = e_wdata;
      end else begin
        wbeat_go = bus.mem_dma_data_yumi_i;
        bus.mem_dma_data_o        = bus.dma_data_i[wid_r];
        bus.mem_dma_data_v_o      = bus.dma_data_v_i[wid_r];
        bus.dma_data_yumi_o[wid_r] = wbeat_go;
        if (wbeat_go && wbeat_r == last_beat)
          state_n = e_idle;
      end
      // Read return runs independently of the packet/write side.
      if (!fifo_empty) begin
        bus.dma_data_o[head]         = bus.mem_dma_data_i;
        bus.dma_data_v_o[head]       = bus.mem_dma_data_v_i;
        bus.mem_dma_data_ready_and_o = bus.dma_data_ready_and_i[head];
        rbeat_go = bus.mem_dma_data_v_i & bus.dma_data_ready_and_i[head];
      end
    end
  end

  assign push = pkt_go & ~pkt_wnr;
  assign pop  = rbeat_go & (rbeat_r == last_beat);

  // Control state: FSM, selection lock, priority pointer, beat counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_idle;
      lock_r     <= 1'b0;
      lock_sel_r <= '0;
      rr_ptr_r   <= '0;
      wid_r      <= '0;
      wbeat_r    <= '0;
      rbeat_r    <= '0;
    end else begin
      state_r <= state_n;
      if (pkt_v && !pkt_go) begin
        lock_r     <= 1'b1;
        lock_sel_r <= sel;
      end else if (pkt_go) begin
        lock_r <= 1'b0;
      end
      if (pkt_go) begin
        rr_ptr_r <= (sel == last_sel) ? '0 : sel + 1'b1;
        if (pkt_wnr) begin
          wid_r   <= sel;
          wbeat_r <= '0;
        end
      end
      if (wbeat_go)
        wbeat_r <= (wbeat_r == last_beat) ? '0 : wbeat_r + 1'b1;
      if (rbeat_go)
        rbeat_r <= (rbeat_r == last_beat) ? '0 : rbeat_r + 1'b1;
    end
  end

  // Read-id FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fifo_wptr_r <= '0;
      fifo_rptr_r <= '0;
      fifo_cnt_r  <= '0;
    end else begin
      if (push)
        fifo_wptr_r <= (fifo_wptr_r == last_fptr) ? '0 : fifo_wptr_r + 1'b1;
      if (pop)
        fifo_rptr_r <= (fifo_rptr_r == last_fptr) ? '0 : fifo_rptr_r + 1'b1;
      if (push && !pop)
        fifo_cnt_r <= fifo_cnt_r + 1'b1;
      else if (pop && !push)
        fifo_cnt_r <= fifo_cnt_r - 1'b1;
    end
  end

  // FIFO storage needs no reset; occupancy gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[fifo_wptr_r] <= sel;
  end

`ifdef BP_ME_DMA_ARBITER_CHECK_EN
  // Simulation-only protocol checks on the memory and cache sides.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (bus.mem_dma_data_v_i && fifo_empty)
        $error("bp_me_dma_arbiter: read data with no outstanding read");
      if (state_r == e_idle && lock_r && !bus.dma_pkt_v_i[lock_sel_r])
        $error("bp_me_dma_arbiter: locked requester dropped valid before yumi");
    end
  end
`endif
endmodule

// File: tb/tb_bp_me_dma_arbiter.sv
// Directed bench for bp_me_dma_arbiter with default parameters
// (2 requesters, 8 beats, 4-deep read FIFO).
module tb_bp_me_dma_arbiter;
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [45:0] r0 = {1'b0, 45'h100};
  localparam logic [45:0] r1 = {1'b0, 45'h200};
  localparam logic [45:0] w1 = {1'b1, 45'h300};

  always #5 clk_i = ~clk_i;

  bp_me_dma_arbiter_if #(.num_dma_p(2), .dma_pkt_width_p(46), .fill_width_p(64)) bus ();

  bp_me_dma_arbiter #(
    .num_dma_p(2), .dma_pkt_width_p(46), .fill_width_p(64),
    .fill_beats_p(8), .rd_fifo_els_p(4)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pkt_v"},  bus.mem_dma_pkt_v_o, 0);
    chk({tag, "_pyumi"},  bus.dma_pkt_yumi_o, 0);
    chk({tag, "_wr_v"},   bus.mem_dma_data_v_o, 0);
    chk({tag, "_dyumi"},  bus.dma_data_yumi_o, 0);
    chk({tag, "_rdy"},    bus.mem_dma_data_ready_and_o, 0);
    chk({tag, "_rd_v"},   bus.dma_data_v_o, 0);
  endtask

  initial begin
    int xfers;
    int wb;
    int h;
    logic [1:0] rdy;

    bus.dma_pkt_i            = '0;
    bus.dma_pkt_v_i          = '0;
    bus.dma_data_ready_and_i = '0;
    bus.dma_data_i           = '0;
    bus.dma_data_v_i         = '0;
    bus.mem_dma_pkt_yumi_i   = 1'b0;
    bus.mem_dma_data_i       = '0;
    bus.mem_dma_data_v_i     = 1'b0;
    bus.mem_dma_data_yumi_i  = 1'b0;

    // Reset with live inputs: every output must stay low.
    bus.dma_pkt_i[0]        = r0;
    bus.dma_pkt_i[1]        = r1;
    bus.dma_pkt_v_i         = 2'b11;
    bus.mem_dma_pkt_yumi_i  = 1'b1;
    bus.mem_dma_data_v_i    = 1'b1;
    bus.dma_data_ready_and_i = 2'b11;
    bus.mem_dma_data_yumi_i = 1'b1;
    step();
    #1;
    chk_all_zero("rst");
    bus.mem_dma_data_v_i    = 1'b0;
    bus.mem_dma_data_yumi_i = 1'b0;
    bus.dma_data_ready_and_i = 2'b00;
    step();

    // Two reads, pointer at 0: grant 0 then 1.
    reset_n_i = 1'b1;
    #1;
    chk("a_pkt_v", bus.mem_dma_pkt_v_o, 1);
    chk("a_pkt0", bus.mem_dma_pkt_o, r0);
    chk("a_yumi0", bus.dma_pkt_yumi_o, 2'b01);
    step();
    bus.dma_pkt_v_i = 2'b10;
    #1;
    chk("a_pkt1", bus.mem_dma_pkt_o, r1);
    chk("a_yumi1", bus.dma_pkt_yumi_o, 2'b10);
    step();
    bus.dma_pkt_v_i = 2'b00;
    bus.mem_dma_data_v_i = 1'b1;
    #1;
    chk("a_idle_v", bus.mem_dma_pkt_v_o, 0);
    chk("a_head0", bus.dma_data_v_o, 2'b01);
    chk("a_rdy_off", bus.mem_dma_data_ready_and_o, 0);
    bus.mem_dma_data_v_i = 1'b0;

    // Write from 1 stalled 4 cycles; higher-priority read from 0 must not steal it.
    bus.dma_pkt_i[1] = w1;
    bus.dma_pkt_v_i  = 2'b10;
    bus.mem_dma_pkt_yumi_i = 1'b0;
    #1;
    chk("b_pkt_w1", bus.mem_dma_pkt_o, w1);
    chk("b_noyumi", bus.dma_pkt_yumi_o, 0);
    step();
    bus.dma_pkt_v_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b_lock_pkt", bus.mem_dma_pkt_o, w1);
      chk("b_lock_yumi", bus.dma_pkt_yumi_o, 0);
      step();
    end
    bus.mem_dma_pkt_yumi_i = 1'b1;
    #1;
    chk("b_grant", bus.dma_pkt_yumi_o, 2'b10);
    step();

    // Write beats 0x10..0x17; no packets offered meanwhile.
    bus.mem_dma_pkt_yumi_i = 1'b0;
    bus.dma_pkt_v_i = 2'b01;
    bus.mem_dma_data_yumi_i = 1'b1;
    bus.dma_data_v_i = 2'b10;
    for (int k = 0; k < 8; k++) begin
      bus.dma_data_i[1] = 64'h10 + 64'(k);
      #1;
      chk("c_wdata", bus.mem_dma_data_o, 64'h10 + 64'(k));
      chk("c_wyumi", bus.dma_data_yumi_o, 2'b10);
      chk("c_nopkt", bus.mem_dma_pkt_v_o, 0);
      step();
    end
    #1;
    chk("c_done_v", bus.mem_dma_data_v_o, 0);
    chk("c_done_yumi", bus.dma_data_yumi_o, 0);
    chk("c_pkt_r0", bus.mem_dma_pkt_o, r0);
    bus.mem_dma_data_yumi_i = 1'b0;
    bus.dma_data_v_i = 2'b00;

    // Fill the FIFO to {0,1,0,1}; pointer was 0 after the write from 1.
    bus.mem_dma_pkt_yumi_i = 1'b1;
    bus.dma_pkt_i[1] = r1;
    bus.dma_pkt_v_i  = 2'b11;
    #1;
    chk("d_grant0", bus.dma_pkt_yumi_o, 2'b01);
    step();
    #1;
    chk("d_grant1", bus.dma_pkt_yumi_o, 2'b10);
    step();
    bus.dma_pkt_v_i = 2'b01;
    #1;
    chk("d_full_hold", bus.mem_dma_pkt_v_o, 0);
    bus.dma_pkt_i[1] = w1;
    bus.dma_pkt_v_i  = 2'b11;
    #1;
    chk("d_full_wr", bus.dma_pkt_yumi_o, 2'b10);
    chk("d_full_pkt", bus.mem_dma_pkt_o, w1);
    step();
    bus.dma_pkt_v_i = 2'b00;
    bus.mem_dma_pkt_yumi_i = 1'b0;

    // Read return to head 0 with toggling ready, concurrent with write beats.
    xfers = 0;
    wb = 0;
    bus.mem_dma_data_v_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rdy = {1'b1, c[0]};
      bus.dma_data_ready_and_i = rdy;
      bus.mem_dma_data_i = 64'hA0 + 64'(c);
      bus.dma_data_v_i = 2'b10;
      bus.dma_data_i[1] = 64'h20 + 64'(wb);
      bus.mem_dma_data_yumi_i = (wb < 8);
      h = (xfers < 8) ? 0 : 1;
      #1;
      chk("e_rd_v", bus.dma_data_v_o, (h == 0) ? 2'b01 : 2'b10);
      chk("e_rd_rdy", bus.mem_dma_data_ready_and_o, rdy[h]);
      chk("e_rd_data", bus.dma_data_o[h], 64'hA0 + 64'(c));
      if (wb < 8) begin
        chk("e_wdata", bus.mem_dma_data_o, 64'h20 + 64'(wb));
        wb++;
      end else begin
        chk("e_widle", bus.mem_dma_data_v_o, 0);
      end
      if (h == 0 && rdy[0]) xfers++;
      step();
    end
    bus.mem_dma_data_v_i = 1'b0;
    bus.dma_data_ready_and_i = 2'b00;
    bus.dma_data_v_i = 2'b00;
    bus.mem_dma_data_yumi_i = 1'b0;

    // Reset in the middle of write beat 3.
    bus.dma_pkt_v_i = 2'b10;
    bus.mem_dma_pkt_yumi_i = 1'b1;
    #1;
    chk("f_grant", bus.dma_pkt_yumi_o, 2'b10);
    step();
    bus.dma_pkt_v_i = 2'b00;
    bus.dma_data_v_i = 2'b10;
    bus.mem_dma_data_yumi_i = 1'b1;
    step();
    step();
    step();
    bus.mem_dma_data_v_i = 1'b1;
    bus.dma_data_ready_and_i = 2'b11;
    #1;
    chk("f_pre_wv", bus.mem_dma_data_v_o, 1);
    chk("f_pre_rdy", bus.mem_dma_data_ready_and_o, 1);
    reset_n_i = 1'b0;
    #1;
    chk_all_zero("f_rst");
    step();
    reset_n_i = 1'b1;
    #1;
    chk_all_zero("f_post");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bp_me_dma_arbiter.md
BP_ME_DMA_ARBITER -- requirements
Module: bp_me_dma_arbiter

Interface
REQ-001 SHALL have parameter num_dma_p, default 2: number of cache-side DMA requesters, 1..16.
REQ-002 SHALL have parameter dma_pkt_width_p, default 46: DMA packet width; bit [dma_pkt_width_p-1] is write_not_read.
REQ-003 SHALL have parameter fill_width_p, default 64: data beat width.
REQ-004 SHALL have parameter fill_beats_p, default 8: beats per block transfer.
REQ-005 SHALL have parameter rd_fifo_els_p, default 4: outstanding read depth.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk_i  in  1  sole clock, all state rising-edge.
REQ-008 reset_n_i  in  1  asynchronous active-low reset.
REQ-009 dma_pkt_i / dma_pkt_v_i / dma_pkt_yumi_o  in/in/out  [num_dma_p][dma_pkt_width_p] / [num_dma_p] / [num_dma_p]  cache-side packets.
REQ-010 dma_data_o / dma_data_v_o / dma_data_ready_and_i  out/out/in  [num_dma_p][fill_width_p] / [num_dma_p] / [num_dma_p]  read data to caches.
REQ-011 dma_data_i / dma_data_v_i / dma_data_yumi_o  in/in/out  [num_dma_p][fill_width_p] / [num_dma_p] / [num_dma_p]  write data from caches.
REQ-012 mem_dma_pkt_o / mem_dma_pkt_v_o / mem_dma_pkt_yumi_i  out/out/in  dma_pkt_width_p / 1 / 1  memory-side packet.
REQ-013 mem_dma_data_i / mem_dma_data_v_i / mem_dma_data_ready_and_o  in/in/out  fill_width_p / 1 / 1  memory read data.
REQ-014 mem_dma_data_o / mem_dma_data_v_o / mem_dma_data_yumi_i  out/out/in  fill_width_p / 1 / 1  memory write data.

Function
REQ-015 SHALL implement FSM states e_idle, e_wdata.
REQ-016 In e_idle: requester i eligible iff dma_pkt_v_i[i] and (write_not_read or read FIFO not full).
REQ-017 Round-robin: lowest index at or after priority pointer wins; pointer <= winner+1 mod num_dma_p on mem_dma_pkt_yumi_i.
REQ-018 Once mem_dma_pkt_v_o asserts without yumi, selected requester SHALL be locked until yumi, regardless of new requests.
REQ-019 mem_dma_pkt_o = dma_pkt_i[sel]; dma_pkt_yumi_o[sel] = mem_dma_pkt_yumi_i, same cycle (zero latency); other yumi bits 0.
REQ-020 Read packet accepted: push sel into read FIFO same edge; remain e_idle.
REQ-021 Write packet accepted: record sel as wid, clear beat counter, go e_wdata; no packets presented in e_wdata.
REQ-022 e_wdata: mem_dma_data_o/v_o = dma_data_i/v_i[wid]; dma_data_yumi_o[wid] = mem_dma_data_yumi_i; counter increments per yumi; yumi on beat fill_beats_p-1 returns to e_idle next cycle.
REQ-023 Read return: FIFO head h gets dma_data_o[h]=mem_dma_data_i, dma_data_v_o[h]=mem_dma_data_v_i; mem_dma_data_ready_and_o = dma_data_ready_and_i[h] and FIFO non-empty.
REQ-024 Read beat counter increments per v&ready; on beat fill_beats_p-1 pop FIFO, clear counter.
REQ-025 Read return and write forwarding SHALL proceed concurrently; FIFO push and pop in same cycle both take effect.
REQ-026 FIFO full: read packets ineligible; writes still granted. FIFO empty: mem_dma_data_ready_and_o=0, all dma_data_v_o=0.

Reset
REQ-027 On reset_n_i low, immediately: state e_idle, pointer 0, lock cleared, counters 0, FIFO empty.
REQ-028 During reset all outputs 0: yumi, valids, ready_and, mem_dma_pkt_v_o; in-flight transfers abandoned, no resume.

Configuration
REQ-029 Macro BP_ME_DMA_ARBITER_CHECK_EN defined: nonsynth checks $error on mem_dma_data_v_i with FIFO empty, and on dma_pkt_v_i deassert while locked without yumi.
REQ-030 Undefined: no checks compiled; mem_dma_data_v_i with FIFO empty silently dropped; functional behaviour otherwise identical.

Verification
REQ-031 Reqs 0,1 both read valid, pointer 0, mem yumi every cycle -> grants 0 then 1, FIFO holds {0,1}, pointer 0.
REQ-032 Req 1 write then 8 data beats 0x10..0x17, mem yumi every cycle -> mem_dma_data_o sequence 0x10..0x17, back to e_idle cycle after 8th.
REQ-033 rd_fifo_els_p=4, 4 reads accepted, no return -> 5th read held, write from another requester still granted.
REQ-034 mem yumi withheld 3 cycles, higher-priority req appears -> original selection held, granted on yumi.
REQ-035 Read return 8 beats with dma_data_ready_and_i[h] toggling -> exactly 8 transfers to h, pop after 8th.
REQ-036 Assert reset_n_i mid e_wdata beat 3 -> all outputs 0 immediately, e_idle, FIFO empty after release.
